// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the round-robin memory controller: the per-channel
// state encoding and a small index helper.
package gpu_mem_pkg;

    typedef enum logic [2:0] {
        CH_IDLE,
        CH_READ_WAIT,
        CH_WRITE_WAIT,
        CH_READ_RELAY,
        CH_WRITE_RELAY
    } chan_state_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set bit of req at or after start,
// wrapping modulo NC.
module rr_pick #(
    parameter int NC = 8
) (
    input  logic [NC-1:0]         req,
    input  logic [$clog2(NC)-1:0] start,
    output logic                  found,
    output logic [$clog2(NC)-1:0] idx
);
    localparam int IW = $clog2(NC);

    logic [NC-1:0] rot;
    logic [IW-1:0] off;
    logic [IW:0]   sum;

    always_comb begin
        // Rotating the doubled mask puts consumer 'start' at bit 0.
        rot   = NC'({req, req} >> start);
        found = 1'b0;
        off   = '0;
        for (int k = NC - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = IW'(k);
            end
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= (IW + 1)'(NC)) begin
            sum = sum - (IW + 1)'(NC);
        end
        idx = sum[IW-1:0];
    end

endmodule

// File: rtl/rr_mem_controller.sv
// Multi-channel memory controller: NUM_CONSUMERS request ports shared over
// NUM_CHANNELS memory channels with round-robin grants.
module rr_mem_controller
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 2,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_error,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);
    localparam int NC  = NUM_CONSUMERS;
    localparam int NCH = NUM_CHANNELS;
    localparam int IW  = $clog2(NC);
    localparam int AW  = ADDR_BITS;
    localparam int DW  = DATA_BITS;

    chan_state_t   state_q [NCH];
    chan_state_t   state_d [NCH];
    logic [IW-1:0] cur_q   [NCH];
    logic [IW-1:0] cur_d   [NCH];
    logic [NC-1:0] busy_q, busy_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;

    logic [NCH-1:0] mrv_q, mrv_d, mwv_q, mwv_d;
    logic [AW-1:0]  mra_q [NCH];
    logic [AW-1:0]  mra_d [NCH];
    logic [AW-1:0]  mwa_q [NCH];
    logic [AW-1:0]  mwa_d [NCH];
    logic [DW-1:0]  mwd_q [NCH];
    logic [DW-1:0]  mwd_d [NCH];
    logic [NC-1:0]  crr_q, crr_d, cwr_q, cwr_d, cwe_q, cwe_d;
    logic [DW-1:0]  crd_q [NC];
    logic [DW-1:0]  crd_d [NC];

    logic [AW-1:0]  c_raddr [NC];
    logic [AW-1:0]  c_waddr [NC];
    logic [DW-1:0]  c_wdata [NC];
    logic [DW-1:0]  m_rdata [NCH];
    logic [NC-1:0]  eligible;
    logic [NCH-1:0] pick_found;
    logic [IW-1:0]  pick_idx [NCH];
    logic [IW-1:0]  j;

    assign eligible = (consumer_read_valid | consumer_write_valid) & ~busy_q;

    genvar gi;
    generate
        for (gi = 0; gi < NC; gi++) begin : g_cons
            assign c_raddr[gi] = consumer_read_address[gi*AW +: AW];
            assign c_waddr[gi] = consumer_write_address[gi*AW +: AW];
            assign c_wdata[gi] = consumer_write_data[gi*DW +: DW];
            assign consumer_read_data[gi*DW +: DW] = crd_q[gi];
        end

        // Each idle channel searches only what earlier channels left untaken.
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            logic [NC-1:0] avail_in, avail_out, take;
            logic          found, idle;
            logic [IW-1:0] idx;
            if (gi == 0) begin : g_first
                assign avail_in = eligible;
            end else begin : g_next
                assign avail_in = g_chan[gi-1].avail_out;
            end
            rr_pick #(.NC(NC)) u_pick (
                .req(avail_in), .start(rr_ptr_q), .found(found), .idx(idx)
            );
            assign idle           = (state_q[gi] == CH_IDLE);
            assign take           = (idle && found) ? (NC'(1) << idx) : '0;
            assign avail_out      = avail_in & ~take;
            assign pick_found[gi] = idle & found;
            assign pick_idx[gi]   = idx;
            assign m_rdata[gi]    = mem_read_data[gi*DW +: DW];
            assign mem_read_address[gi*AW +: AW]  = mra_q[gi];
            assign mem_write_address[gi*AW +: AW] = mwa_q[gi];
            assign mem_write_data[gi*DW +: DW]    = mwd_q[gi];
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        busy_d   = busy_q;
        rr_ptr_d = rr_ptr_q;
        mrv_d    = mrv_q;
        mra_d    = mra_q;
        mwv_d    = mwv_q;
        mwa_d    = mwa_q;
        mwd_d    = mwd_q;
        crr_d    = crr_q;
        crd_d    = crd_q;
        cwr_d    = cwr_q;
        cwe_d    = cwe_q;
        j        = '0;
        for (int i = 0; i < NCH; i++) begin
            case (state_q[i])
                CH_IDLE: begin
                    if (pick_found[i]) begin
                        j         = pick_idx[i];
                        busy_d[j] = 1'b1;
                        cur_d[i]  = j;
                        rr_ptr_d  = IW'(wrap_inc(int'(j), NC));
                        if (consumer_read_valid[j]) begin
                            mrv_d[i]   = 1'b1;
                            mra_d[i]   = c_raddr[j];
                            state_d[i] = CH_READ_WAIT;
                        end else if (WRITE_ENABLE != 0) begin
                            mwv_d[i]   = 1'b1;
                            mwa_d[i]   = c_waddr[j];
                            mwd_d[i]   = c_wdata[j];
                            state_d[i] = CH_WRITE_WAIT;
                        end else begin
                            cwr_d[j]   = 1'b1;
                            cwe_d[j]   = 1'b1;
                            state_d[i] = CH_WRITE_RELAY;
                        end
                    end
                end
                CH_READ_WAIT: begin
                    j = cur_q[i];
                    if (mem_read_ready[i]) begin
                        mrv_d[i]   = 1'b0;
                        crd_d[j]   = m_rdata[i];
                        crr_d[j]   = 1'b1;
                        state_d[i] = CH_READ_RELAY;
                    end
                end
                CH_WRITE_WAIT: begin
                    j = cur_q[i];
                    if (mem_write_ready[i]) begin
                        mwv_d[i]   = 1'b0;
                        cwr_d[j]   = 1'b1;
                        state_d[i] = CH_WRITE_RELAY;
                    end
                end
                CH_READ_RELAY: begin
                    j = cur_q[i];
                    if (!consumer_read_valid[j]) begin
                        crr_d[j]   = 1'b0;
                        busy_d[j]  = 1'b0;
                        state_d[i] = CH_IDLE;
                    end
                end
                CH_WRITE_RELAY: begin
                    j = cur_q[i];
                    if (!consumer_write_valid[j]) begin
                        cwr_d[j]   = 1'b0;
                        cwe_d[j]   = 1'b0;
                        busy_d[j]  = 1'b0;
                        state_d[i] = CH_IDLE;
                    end
                end
                default: state_d[i] = CH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= CH_IDLE;
                cur_q[i]   <= '0;
                mra_q[i]   <= '0;
                mwa_q[i]   <= '0;
                mwd_q[i]   <= '0;
            end
            for (int c = 0; c < NC; c++) begin
                crd_q[c] <= '0;
            end
            busy_q   <= '0;
            rr_ptr_q <= '0;
            mrv_q    <= '0;
            mwv_q    <= '0;
            crr_q    <= '0;
            cwr_q    <= '0;
            cwe_q    <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            mra_q    <= mra_d;
            mwa_q    <= mwa_d;
            mwd_q    <= mwd_d;
            crd_q    <= crd_d;
            busy_q   <= busy_d;
            rr_ptr_q <= rr_ptr_d;
            mrv_q    <= mrv_d;
            mwv_q    <= mwv_d;
            crr_q    <= crr_d;
            cwr_q    <= cwr_d;
            cwe_q    <= cwe_d;
        end
    end

    assign mem_read_valid       = mrv_q;
    assign mem_write_valid      = mwv_q;
    assign consumer_read_ready  = crr_q;
    assign consumer_write_ready = cwr_q;
    assign consumer_write_error = cwe_q;

endmodule

// File: tb/tb_rr_mem_controller.sv
// Directed bench: dut_a has two channels with writes enabled, dut_b one
// read-only channel. Memory responders return {~addr, addr}.
module tb_rr_mem_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic [7:0]   a_rv, a_rr, a_wv, a_wr, a_we;
    logic [63:0]  a_ra, a_wa;
    logic [127:0] a_rd, a_wd;
    logic [1:0]   a_mrv, a_mrr, a_mwv, a_mwr;
    logic [15:0]  a_mra, a_mwa;
    logic [31:0]  a_mrd, a_mwd;

    logic [7:0]   b_rv, b_rr, b_wv, b_wr, b_we;
    logic [63:0]  b_ra, b_wa;
    logic [127:0] b_rd, b_wd;
    logic [0:0]   b_mrv, b_mrr, b_mwv, b_mwr;
    logic [7:0]   b_mra, b_mwa;
    logic [15:0]  b_mrd, b_mwd;

    int n_pass   = 0;
    int n_checks = 0;
    int a_delay  = 0;

    rr_mem_controller #(.NUM_CHANNELS(2), .WRITE_ENABLE(1)) dut_a (
        .clk(clk), .reset(reset),
        .consumer_read_valid(a_rv), .consumer_read_address(a_ra),
        .consumer_read_ready(a_rr), .consumer_read_data(a_rd),
        .consumer_write_valid(a_wv), .consumer_write_address(a_wa),
        .consumer_write_data(a_wd), .consumer_write_ready(a_wr),
        .consumer_write_error(a_we),
        .mem_read_valid(a_mrv), .mem_read_address(a_mra),
        .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
        .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
        .mem_write_data(a_mwd), .mem_write_ready(a_mwr)
    );

    rr_mem_controller #(.NUM_CHANNELS(1), .WRITE_ENABLE(0)) dut_b (
        .clk(clk), .reset(reset),
        .consumer_read_valid(b_rv), .consumer_read_address(b_ra),
        .consumer_read_ready(b_rr), .consumer_read_data(b_rd),
        .consumer_write_valid(b_wv), .consumer_write_address(b_wa),
        .consumer_write_data(b_wd), .consumer_write_ready(b_wr),
        .consumer_write_error(b_we),
        .mem_read_valid(b_mrv), .mem_read_address(b_mra),
        .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
        .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
        .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
    );

    function automatic logic [15:0] rd_model(input logic [7:0] a);
        return {~a, a};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s = %0h", tag, got);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory responders: raise ready for one cycle a_delay cycles after valid.
    initial begin
        int cnt_a [2];
        cnt_a[0] = 0;
        cnt_a[1] = 0;
        a_mrr = '0;
        a_mrd = '0;
        b_mrr = '0;
        b_mrd = '0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                if (a_mrv[c] && !a_mrr[c]) begin
                    if (cnt_a[c] >= a_delay) begin
                        a_mrr[c] = 1'b1;
                        a_mrd[c*16 +: 16] = rd_model(a_mra[c*8 +: 8]);
                    end else begin
                        cnt_a[c]++;
                    end
                end else begin
                    a_mrr[c] = 1'b0;
                    cnt_a[c] = 0;
                end
            end
            if (b_mrv[0] && !b_mrr[0]) begin
                b_mrr[0] = 1'b1;
                b_mrd = rd_model(b_mra);
            end else begin
                b_mrr[0] = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] expv;
        int         j;
        reset = 1'b0;
        a_rv = '0; a_ra = '0; a_wv = '0; a_wa = '0; a_wd = '0; a_mwr = '1;
        b_rv = '0; b_ra = '0; b_wv = '0; b_wa = '0; b_wd = '0; b_mwr = '1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_mrv", a_mrv, 0);
        check("rst_a_rr", a_rr, 0);
        check("rst_b_we", b_we, 0);
        reset = 1'b1;
        step();

        // Three simultaneous reads on two channels.
        a_ra[0*8 +: 8] = 8'h10;
        a_ra[1*8 +: 8] = 8'h20;
        a_ra[2*8 +: 8] = 8'h30;
        a_rv = 8'h07;
        step();
        check("t28_mrv", a_mrv, 2'b11);
        check("t28_mra", a_mra, 16'h2010);
        step();
        check("t28_rr", a_rr, 8'h03);
        check("t28_rd0", a_rd[15:0], rd_model(8'h10));
        check("t28_rd1", a_rd[31:16], rd_model(8'h20));
        a_rv[0] = 1'b0;
        step();
        check("t28_rel0", a_rr, 8'h02);
        step();
        check("t28_mrv2", a_mrv, 2'b01);
        check("t28_mra2", a_mra[7:0], 8'h30);
        step();
        check("t28_rr2", a_rr, 8'h06);
        check("t28_rd2", a_rd[47:32], rd_model(8'h30));
        check("t28_hold0", a_rd[15:0], rd_model(8'h10));
        a_rv = '0;
        step();
        check("t28_idle", a_rr, 8'h00);

        // Slow memory, consumer drops valid while waiting.
        a_delay = 5;
        a_ra[3*8 +: 8] = 8'h44;
        a_rv[3] = 1'b1;
        step();
        check("t31_mrv", a_mrv, 2'b01);
        check("t31_mra", a_mra[7:0], 8'h44);
        a_rv[3] = 1'b0;
        for (int k = 0; k < 20 && !a_rr[3]; k++) step();
        check("t31_rr", a_rr, 8'h08);
        check("t31_rd3", a_rd[63:48], rd_model(8'h44));
        step();
        check("t31_release", a_rr, 8'h00);
        a_delay = 100;
        a_ra[3*8 +: 8] = 8'h55;
        a_rv[3] = 1'b1;
        step();
        check("t31_regrant", a_mrv, 2'b01);
        check("t31_regrant_addr", a_mra[7:0], 8'h55);

        // Asynchronous reset in the middle of READ_WAIT.
        step();
        step();
        check("t32_in_wait", a_mrv, 2'b01);
        #3;
        reset = 1'b0;
        #1;
        check("t32_mrv", a_mrv, 0);
        check("t32_mra", a_mra, 0);
        check("t32_rd", a_rd, 0);
        check("t32_rr_wr", {a_rr, a_wr, a_we, 6'b0, a_mwv}, 0);
        a_rv = '0;
        a_delay = 0;
        step();
        reset = 1'b1;
        for (int c = 0; c < 8; c++) a_ra[c*8 +: 8] = 8'h80 + 8'(c);
        a_rv = 8'hFF;
        step();
        check("t32_first_mrv", a_mrv, 2'b11);
        check("t32_first_mra", a_mra, 16'h8180);
        a_rv = '0;
        repeat (4) step();

        // Read-only controller, one channel, everyone requesting.
        for (int c = 0; c < 8; c++) b_ra[c*8 +: 8] = 8'(c * 16 + 3);
        b_rv = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            j = g % 8;
            for (int k = 0; k < 10 && !b_mrv[0]; k++) step();
            check($sformatf("t29_grant%0d_addr", g), b_mra, 8'(j * 16 + 3));
            for (int k = 0; k < 10 && b_rr == 0; k++) step();
            expv = 8'h01 << j;
            check($sformatf("t29_grant%0d_rr", g), b_rr, expv);
            b_rv[j] = 1'b0;
            step();
            b_rv[j] = 1'b1;
        end
        b_rv = '0;
        repeat (3) step();

        // Rejected write when writes are disabled.
        b_wa[2*8 +: 8] = 8'h05;
        b_wd[2*16 +: 16] = 16'h1234;
        b_wv[2] = 1'b1;
        step();
        check("t30_wr", b_wr, 8'h04);
        check("t30_we", b_we, 8'h04);
        check("t30_mwv", b_mwv, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t30_hold%0d", k), {b_wr, b_we, 7'b0, b_mwv}, {8'h04, 8'h04, 8'h00});
        end
        b_wv = '0;
        step();
        check("t30_clear", {b_wr, b_we}, 0);

        // Read wins over write on the same consumer.
        b_ra[4*8 +: 8] = 8'h4C;
        b_wa[4*8 +: 8] = 8'h4D;
        b_rv[4] = 1'b1;
        b_wv[4] = 1'b1;
        step();
        check("t17_mrv", b_mrv, 1'b1);
        check("t17_mra", b_mra, 8'h4C);
        check("t17_wr", {b_wr, b_we}, 0);
        for (int k = 0; k < 10 && !b_rr[4]; k++) step();
        check("t17_rd", b_rd[79:64], rd_model(8'h4C));
        b_rv = '0;
        b_wv = '0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
